muxn_scan: RTL

MUXN_SCAN -- requirements
Module: muxn_scan

---
 rtl/muxn_scan.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/muxn_scan.sv
// N-channel registered multiplexer with a manual-select mode and a one-shot ascending scan pass.
// Optional build macro MUXN_MASK_EN adds a per-channel mask port that limits which channels a pass visits.
module muxn_scan #(
    parameter int N  = 4,
    parameter int W  = 1,
    localparam int SW = (N > 2) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    input  logic           start,
`ifdef MUXN_MASK_EN
    input  logic [N-1:0]   mask,
`endif
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    output logic [SW-1:0]  out_ch,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t        state_reg;
    logic [SW-1:0] ctr_reg;
    logic [W-1:0]  out_data_reg;
    logic [SW-1:0] out_ch_reg;
    logic          out_valid_reg;
    logic          busy_reg;
    logic          done_reg;

    logic [W-1:0]  chan [N];
    logic [N-1:0]  start_mask;
    logic [N-1:0]  scan_mask;
    logic [SW-1:0] first_ch;
    logic          first_ok;
    logic [SW-1:0] next_ch;
    logic          next_ok;
    logic          sel_ok;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign chan[gi] = in_data[gi*W +: W];
        end
    endgenerate

`ifdef MUXN_MASK_EN
    // The mask is captured on the start edge so a pass is immune to later mask changes.
    logic [N-1:0] mask_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg <= '0;
        end else if (state_reg == IDLE && mode && start) begin
            mask_reg <= mask;
        end
    end

    assign start_mask = mask;
    assign scan_mask  = mask_reg;
`else
    assign start_mask = '1;
    assign scan_mask  = '1;
`endif

    assign sel_ok = int'(sel) < N;

    // Descending loop so the lowest eligible index is the one left standing.
    always_comb begin
        first_ch = '0;
        first_ok = 1'b0;
        next_ch  = '0;
        next_ok  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (start_mask[k]) begin
                first_ch = SW'(k);
                first_ok = 1'b1;
            end
            if (scan_mask[k] && (k > int'(ctr_reg))) begin
                next_ch = SW'(k);
                next_ok = 1'b1;
            end
        end
    end

    // ctr_reg always holds the channel currently presented while in SCAN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ctr_reg       <= '0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    if (!mode) begin
                        if (sel_ok) begin
                            out_data_reg  <= chan[sel];
                            out_ch_reg    <= sel;
                            out_valid_reg <= 1'b1;
                        end else begin
                            out_data_reg  <= '0;
                            out_ch_reg    <= '0;
                            out_valid_reg <= 1'b0;
                        end
                    end else if (start && first_ok) begin
                        state_reg     <= SCAN;
                        ctr_reg       <= first_ch;
                        out_data_reg  <= chan[first_ch];
                        out_ch_reg    <= first_ch;
                        out_valid_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                    end else if (start) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b0;
                        done_reg      <= 1'b1;
                    end else begin
                        out_valid_reg <= 1'b0;
                    end
                end
                SCAN: begin
                    if (next_ok) begin
                        ctr_reg       <= next_ch;
                        out_data_reg  <= chan[next_ch];
                        out_ch_reg    <= next_ch;
                        out_valid_reg <= 1'b1;
                    end else begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg     <= IDLE;
                    ctr_reg       <= '0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b0;
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
